// File: rtl/vslc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vslc_scan_sequencer
// Purpose  : Scan-cycle controller for the VSLC stack executor. At each scan
//            start it snapshots the live inputs. It then fetches the program
//            one byte at a time over a req/ack handshake and issues each
//            instruction with a one-cycle strobe. A scan ends on END_OP or
//            after address PROG_LEN-1.
// Revision : 1.0 - initial release
//
// Optional : `define SCAN_WATCHDOG_EN to enable the per-scan cycle watchdog.
//            Without it, wdt_fault is constant 0 and no counter is built.
//
// Ports
//   clk, rst_n          clock (posedge), synchronous active-low reset
//   run, scan_tick      scan enable / one-cycle scan-start request
//   fault_clr           clears sticky overrun and wdt_fault
//   ui_in               live inputs, snapshotted at scan start
//   mem_req/addr/ack/data  program memory read handshake (ack may be same-cycle)
//   exec_instr, exec_instr_ready  instruction and issue strobe to executor
//   exec_ui_in, exec_ui_in_prev   current / previous scan input snapshots
//   busy                high in SNAP, FETCH and ISSUE
//   scan_done           one-cycle pulse on normal scan completion
//   overrun             sticky: scan start requested while a scan was active
//   wdt_fault           sticky: watchdog aborted a scan
// ============================================================================
module vslc_scan_sequencer #(
  parameter int         ADDR_W     = 8,
  parameter int         PROG_LEN   = 256,
  parameter logic [7:0] END_OP     = 8'hE0,
  parameter bit         FREE_RUN   = 1'b0,
  parameter int         WDT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              scan_tick,
  input  logic              fault_clr,
  input  logic [7:0]        ui_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        exec_instr,
  output logic              exec_instr_ready,
  output logic [7:0]        exec_ui_in,
  output logic [7:0]        exec_ui_in_prev,
  output logic              busy,
  output logic              scan_done,
  output logic              overrun,
  output logic              wdt_fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_FETCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        exec_instr_q, exec_instr_d;
  logic [7:0]        exec_ui_in_q, exec_ui_in_d;
  logic [7:0]        exec_ui_in_prev_q, exec_ui_in_prev_d;
  logic              mem_req_q, mem_req_d;
  logic              exec_instr_ready_q, exec_instr_ready_d;
  logic              busy_q, busy_d;
  logic              scan_done_q, scan_done_d;
  logic              overrun_q, overrun_d;
  logic              wdt_fault_q, wdt_fault_d;
  logic              start;
  logic              abort;
  logic              wdt_limit;

`ifdef SCAN_WATCHDOG_EN
  localparam int               CNT_W    = $clog2(WDT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

  // Counts busy cycles already elapsed in this scan. It is cleared as SNAP is
  // entered, so it reads 0 during SNAP. The WDT_CYCLES-th busy cycle is
  // therefore the one with count WDT_CYCLES-1, and the abort takes effect at
  // the end of that cycle.
  logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;

  assign wdt_limit = (wdt_cnt_q >= WDT_LAST);

  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    if (state_d == ST_SNAP) begin
      wdt_cnt_d = '0;
    end else if (busy_q && !wdt_limit) begin
      wdt_cnt_d = wdt_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_wdt_cfg;
  assign wdt_limit      = 1'b0;
  assign unused_wdt_cfg = (WDT_CYCLES != 0);
`endif

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    exec_instr_d      = exec_instr_q;
    exec_ui_in_d      = exec_ui_in_q;
    exec_ui_in_prev_d = exec_ui_in_prev_q;
    abort             = 1'b0;
    start             = run && (scan_tick || FREE_RUN);

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        exec_ui_in_prev_d = exec_ui_in_q;
        exec_ui_in_d      = ui_in;
        pc_d              = '0;
        state_d           = ST_FETCH;
      end
      ST_FETCH: begin
        // The watchdog takes priority over a coincident ack.
        if (wdt_limit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          if (mem_data == END_OP) begin
            state_d = ST_DONE;
          end else begin
            exec_instr_d = mem_data;
            state_d      = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // The strobe for this cycle is already out; an abort here only
        // suppresses the next fetch.
        if (wdt_limit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (pc_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = (FREE_RUN && run) ? ST_SNAP : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any start request outside IDLE is dropped and flagged. If a clear
    // arrives in the same cycle, the set wins.
    overrun_d = overrun_q;
    if (fault_clr) overrun_d = 1'b0;
    if (scan_tick && (state_q != ST_IDLE)) overrun_d = 1'b1;

    wdt_fault_d = wdt_fault_q;
    if (fault_clr) wdt_fault_d = 1'b0;
    if (abort)     wdt_fault_d = 1'b1;

    // Outputs are registered, so they are decoded from the next state.
    mem_req_d          = (state_d == ST_FETCH);
    exec_instr_ready_d = (state_d == ST_ISSUE);
    scan_done_d        = (state_d == ST_DONE);
    busy_d             = (state_d == ST_SNAP) || (state_d == ST_FETCH) ||
                         (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      pc_q               <= '0;
      exec_instr_q       <= '0;
      exec_ui_in_q       <= '0;
      exec_ui_in_prev_q  <= '0;
      mem_req_q          <= 1'b0;
      exec_instr_ready_q <= 1'b0;
      busy_q             <= 1'b0;
      scan_done_q        <= 1'b0;
      overrun_q          <= 1'b0;
      wdt_fault_q        <= 1'b0;
`ifdef SCAN_WATCHDOG_EN
      wdt_cnt_q          <= '0;
`endif
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      exec_instr_q       <= exec_instr_d;
      exec_ui_in_q       <= exec_ui_in_d;
      exec_ui_in_prev_q  <= exec_ui_in_prev_d;
      mem_req_q          <= mem_req_d;
      exec_instr_ready_q <= exec_instr_ready_d;
      busy_q             <= busy_d;
      scan_done_q        <= scan_done_d;
      overrun_q          <= overrun_d;
      wdt_fault_q        <= wdt_fault_d;
`ifdef SCAN_WATCHDOG_EN
      wdt_cnt_q          <= wdt_cnt_d;
`endif
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_addr         = pc_q;
  assign exec_instr       = exec_instr_q;
  assign exec_instr_ready = exec_instr_ready_q;
  assign exec_ui_in       = exec_ui_in_q;
  assign exec_ui_in_prev  = exec_ui_in_prev_q;
  assign busy             = busy_q;
  assign scan_done        = scan_done_q;
  assign overrun          = overrun_q;
  assign wdt_fault        = wdt_fault_q;

endmodule
`default_nettype wire
